seq_pattern_tx: RTL and testbench

Serial pattern transmitter, the source end of the 1011 sequence-detector link. Captures a PAT_W-bit pattern and a repeat count on a start request, then shifts the pattern out MSB-first, one bit per clock, repeated reps times. Optional idle-zero gap bits separate repetitions. Drives the detector's serial data input in loopback benches and on-chip test paths.

---
 rtl/seq_pattern_tx.sv | 164 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Function : Serial pattern transmitter, MSB-first, repeated with idle gaps.
//            Optional macro SEQ_TX_PARITY_EN appends an even-parity bit per rep.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int GAP_LEN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             d_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_PAR, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [PAT_W-1:0]   r_pat, w_pat_nxt;
  logic [PAT_W-1:0]   r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]   r_rem, w_rem_nxt;
  logic [CNT_W-1:0]   r_sent, w_sent_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_dout, r_valid, r_busy, r_done;
  logic               w_dout_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;
  logic               w_rep_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_shreg <= '0;
      r_rem   <= '0;
      r_sent  <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_shreg <= w_shreg_nxt;
      r_rem   <= w_rem_nxt;
      r_sent  <= w_sent_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_shreg_nxt = r_shreg;
    w_rem_nxt   = r_rem;
    w_sent_nxt  = r_sent;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_rep_end   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat_nxt   = pattern;
          w_shreg_nxt = pattern;
          w_rem_nxt   = reps;
          w_sent_nxt  = '0;
          w_idx_nxt   = C_IDX_LAST;
          w_state_nxt = (reps == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (r_idx != '0) begin
          w_shreg_nxt = r_shreg << 1;
          w_idx_nxt   = r_idx - IDX_W'(1);
        end else begin
`ifdef SEQ_TX_PARITY_EN
          w_state_nxt = S_PAR;
`else
          w_rep_end   = 1'b1;
`endif
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_SEND;
        else             w_gap_nxt   = r_gap - GAP_W'(1);
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: w_rep_end = 1'b1;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // One repetition finished: reload the pattern and pick gap, next rep or done.
    if (w_rep_end) begin
      w_sent_nxt  = r_sent + CNT_W'(1);
      w_rem_nxt   = r_rem - CNT_W'(1);
      w_shreg_nxt = r_pat;
      w_idx_nxt   = C_IDX_LAST;
      w_gap_nxt   = C_GAP_LAST;
      if (r_rem == CNT_W'(1)) w_state_nxt = S_DONE;
      else if (GAP_LEN > 0)   w_state_nxt = S_GAP;
      else                    w_state_nxt = S_SEND;
    end
  end

  // Outputs are decoded from the next state so they leave the flops as Moore outputs.
  always_comb begin
    w_dout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_SEND: begin
        w_dout_nxt  = w_shreg_nxt[PAT_W-1];
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_GAP: w_busy_nxt = 1'b1;
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        w_dout_nxt  = ^r_pat;
        w_valid_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
`endif
      S_DONE:  w_done_nxt = 1'b1;
      default: w_done_nxt = 1'b0;
    endcase
  end

  assign d_out    = r_dout;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// Directed, table-driven bench for seq_pattern_tx; one instance without gaps,
// one with GAP_LEN=2, both driven by the same stimulus.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [7:0] reps;

  logic       d0, v0, b0, dn0;
  logic [7:0] sc0;
  logic       d2, v2, b2, dn2;
  logic [7:0] sc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .d_out(d0), .valid(v0), .busy(b0), .done(dn0), .sent_cnt(sc0)
  );

  seq_pattern_tx #(.PAT_W(4), .CNT_W(8), .GAP_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .d_out(d2), .valid(v2), .busy(b2), .done(dn2), .sent_cnt(sc2)
  );

  typedef struct {
    logic [3:0]  pat;
    logic [7:0]  reps;
    int          len0;
    logic [31:0] s0;
    logic [31:0] va0;
    int          len2;
    logic [31:0] s2;
    logic [31:0] va2;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Expected {d_out, valid, busy, done} at sample step i of a transfer.
  function automatic logic [3:0] expv(input int len, input logic [31:0] s,
                                      input logic [31:0] vv, input int i);
    if (i < len)       return {s[len-1-i], vv[len-1-i], 1'b1, 1'b0};
    else if (i == len) return 4'b0001;
    else               return 4'b0000;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int mx;
    mx = ((v.len0 > v.len2) ? v.len0 : v.len2) + 1;
    @(negedge clk);
    pattern = v.pat;
    reps    = v.reps;
    start   = 1'b1;
    for (int i = 0; i <= mx; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      chk($sformatf("vec%0d gap0 out", id), i, {4'b0, d0, v0, b0, dn0},
          {4'b0, expv(v.len0, v.s0, v.va0, i)});
      chk($sformatf("vec%0d gap2 out", id), i, {4'b0, d2, v2, b2, dn2},
          {4'b0, expv(v.len2, v.s2, v.va2, i)});
      if (i == v.len0) chk($sformatf("vec%0d gap0 sent_cnt", id), i, sc0, v.reps);
      if (i == v.len2) chk($sformatf("vec%0d gap2 sent_cnt", id), i, sc2, v.reps);
    end
  endtask

  logic [3:0] held_exp [12];

  initial begin
    vecs[0] = '{4'b1011, 8'd1, 4,  32'b1011,           32'b1111,
                4,  32'b1011, 32'b1111};
    vecs[1] = '{4'b1011, 8'd3, 12, 32'b1011_1011_1011, 32'hFFF,
                16, 32'b1011_00_1011_00_1011, 32'b1111_00_1111_00_1111};
    vecs[2] = '{4'b0110, 8'd2, 8,  32'b0110_0110,      32'hFF,
                10, 32'b0110_00_0110, 32'b1111_00_1111};
    vecs[3] = '{4'b0001, 8'd2, 8,  32'b0001_0001,      32'hFF,
                10, 32'b0001_00_0001, 32'b1111_00_1111};
    vecs[4] = '{4'b1000, 8'd1, 4,  32'b1000,           32'hF,
                4,  32'b1000, 32'hF};
    vecs[5] = '{4'b1011, 8'd0, 0,  32'b0,              32'b0,
                0,  32'b0, 32'b0};
    vecs[6] = '{4'b1111, 8'd5, 20, 32'hFFFFF,          32'hFFFFF,
                28, 32'b1111_00_1111_00_1111_00_1111_00_1111,
                32'b1111_00_1111_00_1111_00_1111_00_1111};

    // start held high, pattern switched to 0110 mid-transfer
    held_exp = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0001, 4'b0000,
                 4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b0001, 4'b0000};

    rst = 1'b0; start = 1'b0; pattern = 4'b0; reps = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset gap0 out", 0, {4'b0, d0, v0, b0, dn0}, 8'h00);
    chk("reset gap2 out", 0, {4'b0, d2, v2, b2, dn2}, 8'h00);
    chk("reset gap0 sent_cnt", 0, sc0, 8'h00);
    chk("reset gap2 sent_cnt", 0, sc2, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // start held high through a transfer; only IDLE may accept it
    @(negedge clk);
    pattern = 4'b1011; reps = 8'd1; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("held gap0 out", i, {4'b0, d0, v0, b0, dn0}, {4'b0, held_exp[i]});
      chk("held gap2 out", i, {4'b0, d2, v2, b2, dn2}, {4'b0, held_exp[i]});
      if (i == 1) pattern = 4'b0110;
      if (i == 6) start = 1'b0;
    end

    // asynchronous reset in the middle of a pattern
    @(negedge clk);
    pattern = 4'b1011; reps = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rstmid gap0 bit0", 0, {4'b0, d0, v0, b0, dn0}, 8'h0E);
    @(negedge clk);
    chk("rstmid gap0 bit1", 1, {4'b0, d0, v0, b0, dn0}, 8'h06);
    @(negedge clk);
    chk("rstmid gap0 bit2", 2, {4'b0, d0, v0, b0, dn0}, 8'h0E);
    #2 rst = 1'b0;
    #1;
    chk("rstmid gap0 async", 3, {4'b0, d0, v0, b0, dn0}, 8'h00);
    chk("rstmid gap2 async", 3, {4'b0, d2, v2, b2, dn2}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid gap0 idle", i, {4'b0, d0, v0, b0, dn0}, 8'h00);
      chk("rstmid gap2 idle", i, {4'b0, d2, v2, b2, dn2}, 8'h00);
    end
    chk("rstmid gap0 sent_cnt", 0, sc0, 8'h00);

    // normal operation resumes after reset
    run_vec(vecs[2], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
